// File: rtl/fetch_pkg.sv
// Shared types and sizing helpers for the instruction fetch front end.
package fetch_pkg;

  localparam int FETCH_PC_W  = 9;
  localparam int FETCH_INS_W = 32;
  localparam int FETCH_DEPTH = 4;
  localparam int FETCH_CNT_W = $clog2(FETCH_DEPTH) + 1;

  typedef struct packed {
    logic [FETCH_PC_W-1:0]  pc;
    logic [FETCH_INS_W-1:0] instr;
  } fetch_entry_t;

  localparam fetch_entry_t FETCH_BUBBLE = '0;

  // Counters must hold the value DEPTH itself, hence one bit above the pointer width.
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with a single-cycle clear; head shows the oldest entry.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        push,
  input  logic                        pop,
  input  logic                        clear,
  input  logic [WIDTH-1:0]            wdata,
  output logic [WIDTH-1:0]            head,
  output logic [cnt_width(DEPTH)-1:0] count,
  output logic                        full,
  output logic                        empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = cnt_width(DEPTH);
  localparam logic [CW-1:0] FULL_CNT = DEPTH[CW-1:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic             do_push;
  logic             do_pop;

  // A push into a full FIFO is only honoured when the head leaves in the same cycle.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!reset || clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset && !clear && do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/ifetch_queue.sv
// Instruction fetch front end: owns the PC, issues credit-limited memory reads,
// buffers in-order responses with their PCs and handles stall and redirect.
module ifetch_queue
  import fetch_pkg::*;
#(
  parameter int              PC_W     = FETCH_PC_W,
  parameter int              INS_W    = FETCH_INS_W,
  parameter int              DEPTH    = FETCH_DEPTH,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             redirect_valid,
  input  logic [PC_W-1:0]  redirect_pc,
  input  logic             stall,
  output logic             imem_req,
  output logic [PC_W-1:0]  imem_addr,
  input  logic             imem_rvalid,
  input  logic [INS_W-1:0] imem_rdata,
  output logic             if_valid,
  output logic [PC_W-1:0]  if_pc,
  output logic [INS_W-1:0] if_instr
);

  localparam int CW = cnt_width(DEPTH);
  localparam int EW = PC_W + INS_W;
  localparam logic [CW-1:0] DEPTH_CNT = DEPTH[CW-1:0];
  localparam logic [CW:0]   CAP       = {1'b0, DEPTH_CNT};

  logic [PC_W-1:0] fetch_pc;
  logic [PC_W-1:0] redirect_aligned;
  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   drop_cnt;
  logic [CW-1:0]   q_count;
  logic [CW-1:0]   tag_count;
  logic            q_full;
  logic            q_empty;
  logic            tag_full;
  logic            tag_empty;
  logic [EW-1:0]   q_head;
  logic [PC_W-1:0] tag_head;
  logic [CW:0]     credit_used;
  logic            issue;
  logic            resp;
  logic            drop;
  logic            enq;
  logic            deq;

  // Buffered entries plus requests in flight may never exceed the queue size,
  // which guarantees every response has a slot waiting for it.
  assign credit_used = {1'b0, q_count} + {1'b0, outstanding};
  assign issue       = reset && !redirect_valid && (credit_used < CAP);

  // Stray responses with nothing in flight (left over from a reset) are ignored.
  assign resp = imem_rvalid && (outstanding != '0);
  assign drop = resp && (drop_cnt != '0);
  assign enq  = resp && (drop_cnt == '0) && !redirect_valid;
  assign deq  = !q_empty && !stall && !redirect_valid;

  assign redirect_aligned = redirect_pc & ~PC_W'(3);

  assign imem_req  = issue;
  assign imem_addr = fetch_pc;
  assign if_valid  = !q_empty;
  assign {if_pc, if_instr} = q_empty ? '0 : q_head;

  fetch_fifo #(.WIDTH(PC_W), .DEPTH(DEPTH)) u_tag_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (issue),
    .pop   (enq),
    .clear (redirect_valid),
    .wdata (fetch_pc),
    .head  (tag_head),
    .count (tag_count),
    .full  (tag_full),
    .empty (tag_empty)
  );

  fetch_fifo #(.WIDTH(EW), .DEPTH(DEPTH)) u_entry_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (enq),
    .pop   (deq),
    .clear (redirect_valid),
    .wdata ({tag_head, imem_rdata}),
    .head  (q_head),
    .count (q_count),
    .full  (q_full),
    .empty (q_empty)
  );

  // On redirect everything still in flight becomes stale, including a response
  // landing in the same cycle, which is discarded rather than counted.
  always_ff @(posedge clk) begin
    if (!reset) begin
      fetch_pc    <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      outstanding <= outstanding + CW'(issue) - CW'(resp);
      if (redirect_valid) begin
        fetch_pc <= redirect_aligned;
        drop_cnt <= outstanding - CW'(resp);
      end else begin
        if (issue) fetch_pc <= fetch_pc + PC_W'(4);
        if (drop)  drop_cnt <= drop_cnt - 1'b1;
      end
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!reset) !(enq && q_full));
  a_tag_room:    assert property (@(posedge clk) disable iff (!reset) !(issue && tag_full));
  a_tag_present: assert property (@(posedge clk) disable iff (!reset) !(enq && tag_empty));
  a_inflight:    assert property (@(posedge clk) disable iff (!reset)
                                  (tag_count + drop_cnt) == outstanding);
  a_out_bound:   assert property (@(posedge clk) disable iff (!reset) outstanding <= DEPTH_CNT);

endmodule

// File: tb/tb_ifetch_queue.sv
// Directed bench for ifetch_queue with an in-order, fixed-latency memory model.
module tb_ifetch_queue;
  import fetch_pkg::*;

  typedef struct {
    int         due;
    logic [8:0] addr;
  } pend_t;

  logic        clk;
  logic        reset;
  logic        redirect_valid;
  logic [8:0]  redirect_pc;
  logic        stall;
  logic        imem_req;
  logic [8:0]  imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [8:0]  if_pc;
  logic [31:0] if_instr;

  logic        imem_req2;
  logic [8:0]  imem_addr2;
  logic        rvalid2;
  logic [31:0] rdata2;
  logic        if_valid2;
  logic [8:0]  if_pc2;
  logic [31:0] if_instr2;

  int    n_compared;
  int    n_mismatched;
  int    cyc;
  int    lat;
  pend_t pend[$];

  ifetch_queue #(.PC_W(9), .INS_W(32), .DEPTH(4), .RESET_PC(9'h000)) dut (
    .clk            (clk),
    .reset          (reset),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .stall          (stall),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .if_valid       (if_valid),
    .if_pc          (if_pc),
    .if_instr       (if_instr)
  );

  // Second instance never gets responses; it only exercises PC wrap from a high reset PC.
  ifetch_queue #(.PC_W(9), .INS_W(32), .DEPTH(4), .RESET_PC(9'h1F8)) dut_wrap (
    .clk            (clk),
    .reset          (reset),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .stall          (stall),
    .imem_req       (imem_req2),
    .imem_addr      (imem_addr2),
    .imem_rvalid    (rvalid2),
    .imem_rdata     (rdata2),
    .if_valid       (if_valid2),
    .if_pc          (if_pc2),
    .if_instr       (if_instr2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] instr_of(input logic [8:0] a);
    return 32'hC0DE_0000 | {23'd0, a};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // One cycle: drive controls and any due memory response after the falling edge,
  // then record a request the DUT makes in this cycle.
  task automatic applyStimulus(input logic rst, input logic st, input logic rv,
                               input logic [8:0] rpc);
    @(negedge clk);
    cyc++;
    reset          = rst;
    stall          = st;
    redirect_valid = rv;
    redirect_pc    = rpc;
    imem_rvalid    = 1'b0;
    imem_rdata     = '0;
    if (pend.size() != 0 && pend[0].due <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = instr_of(pend[0].addr);
      void'(pend.pop_front());
    end
    #1;
    if (imem_req) pend.push_back('{cyc + lat, imem_addr});
  endtask

  task automatic holdReset(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, 9'h000);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [8:0] wrap_seq [4];
    logic [8:0] drain_seq [5];
    wrap_seq  = '{9'h1F8, 9'h1FC, 9'h000, 9'h004};
    drain_seq = '{9'h000, 9'h004, 9'h008, 9'h00C, 9'h010};

    n_compared     = 0;
    n_mismatched   = 0;
    cyc            = 0;
    lat            = 1;
    reset          = 1'b0;
    stall          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    imem_rvalid    = 1'b0;
    imem_rdata     = '0;
    rvalid2        = 1'b0;
    rdata2         = '0;

    // Reset state, then streaming with L=1 and PC wrap on the second instance.
    holdReset(5);
    checkOutput("rst_req", imem_req, 0);
    checkOutput("rst_addr", imem_addr, 9'h000);
    checkOutput("rst_valid", if_valid, 0);
    checkOutput("rst_pc", if_pc, 0);
    checkOutput("rst_instr", if_instr, 0);
    checkOutput("rst_wrap_addr", imem_addr2, 9'h1F8);
    for (int i = 1; i <= 6; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 9'h000);
      checkOutput($sformatf("s1_req%0d", i), imem_req, 1);
      checkOutput($sformatf("s1_addr%0d", i), imem_addr, 4 * (i - 1));
      if (i <= 4) checkOutput($sformatf("wrap_addr%0d", i), imem_addr2, wrap_seq[i-1]);
      if (i == 5) checkOutput("wrap_req_stop", imem_req2, 0);
      if (i <= 2) begin
        checkOutput($sformatf("s1_valid%0d", i), if_valid, 0);
      end else begin
        checkOutput($sformatf("s1_valid%0d", i), if_valid, 1);
        checkOutput($sformatf("s1_pc%0d", i), if_pc, 4 * (i - 3));
        checkOutput($sformatf("s1_instr%0d", i), if_instr, instr_of(9'(4 * (i - 3))));
      end
    end
    applyStimulus(1'b1, 1'b0, 1'b1, 9'h0A3);
    checkOutput("unal_redir_req", imem_req, 0);
    applyStimulus(1'b1, 1'b0, 1'b0, 9'h000);
    checkOutput("unal_addr", imem_addr, 9'h0A0);
    checkOutput("unal_req", imem_req, 1);

    // Stall fills the queue and starves issue; release drains in order.
    lat = 1;
    holdReset(5);
    for (int i = 1; i <= 6; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 9'h000);
      if (i >= 5) checkOutput($sformatf("stall_req%0d", i), imem_req, 0);
    end
    checkOutput("stall_valid", if_valid, 1);
    checkOutput("stall_head", if_pc, 9'h000);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 9'h000);
      checkOutput($sformatf("drain_valid%0d", i), if_valid, 1);
      checkOutput($sformatf("drain_pc%0d", i), if_pc, drain_seq[i]);
      checkOutput($sformatf("drain_instr%0d", i), if_instr, instr_of(drain_seq[i]));
      if (i == 0) checkOutput("drain_req0", imem_req, 0);
      if (i == 1) checkOutput("drain_addr1", imem_addr, 9'h010);
    end

    // Redirect with three requests in flight at L=3.
    lat = 3;
    holdReset(5);
    for (int i = 1; i <= 3; i++) applyStimulus(1'b1, 1'b0, 1'b0, 9'h000);
    applyStimulus(1'b1, 1'b0, 1'b1, 9'h040);
    checkOutput("l3_redir_req", imem_req, 0);
    applyStimulus(1'b1, 1'b0, 1'b0, 9'h000);
    checkOutput("l3_tgt_req", imem_req, 1);
    checkOutput("l3_tgt_addr", imem_addr, 9'h040);
    checkOutput("l3_valid_t1", if_valid, 0);
    applyStimulus(1'b1, 1'b0, 1'b0, 9'h000);
    checkOutput("l3_addr_t2", imem_addr, 9'h044);
    checkOutput("l3_valid_t2", if_valid, 0);
    applyStimulus(1'b1, 1'b0, 1'b0, 9'h000);
    checkOutput("l3_valid_t3", if_valid, 0);
    applyStimulus(1'b1, 1'b0, 1'b0, 9'h000);
    checkOutput("l3_valid_t4", if_valid, 0);
    applyStimulus(1'b1, 1'b0, 1'b0, 9'h000);
    checkOutput("l3_valid_t5", if_valid, 1);
    checkOutput("l3_pc_t5", if_pc, 9'h040);
    checkOutput("l3_instr_t5", if_instr, instr_of(9'h040));
    applyStimulus(1'b1, 1'b0, 1'b0, 9'h000);
    checkOutput("l3_pc_t6", if_pc, 9'h044);

    // Redirect coinciding with a response while stalled.
    lat = 1;
    holdReset(5);
    for (int i = 1; i <= 3; i++) applyStimulus(1'b1, 1'b1, 1'b0, 9'h000);
    applyStimulus(1'b1, 1'b1, 1'b1, 9'h080);
    checkOutput("rs_redir_req", imem_req, 0);
    checkOutput("rs_pre_valid", if_valid, 1);
    applyStimulus(1'b1, 1'b0, 1'b0, 9'h000);
    checkOutput("rs_cleared", if_valid, 0);
    checkOutput("rs_bubble_pc", if_pc, 0);
    checkOutput("rs_tgt_addr", imem_addr, 9'h080);
    applyStimulus(1'b1, 1'b0, 1'b0, 9'h000);
    checkOutput("rs_valid_t2", if_valid, 0);
    applyStimulus(1'b1, 1'b0, 1'b0, 9'h000);
    checkOutput("rs_valid_t3", if_valid, 1);
    checkOutput("rs_pc_t3", if_pc, 9'h080);
    checkOutput("rs_instr_t3", if_instr, instr_of(9'h080));

    // Reset asserted with two requests in flight.
    lat = 3;
    holdReset(5);
    applyStimulus(1'b1, 1'b0, 1'b0, 9'h000);
    applyStimulus(1'b1, 1'b0, 1'b0, 9'h000);
    holdReset(4);
    checkOutput("mr_req", imem_req, 0);
    checkOutput("mr_addr", imem_addr, 9'h000);
    checkOutput("mr_valid", if_valid, 0);
    checkOutput("mr_pc", if_pc, 0);
    checkOutput("mr_instr", if_instr, 0);
    applyStimulus(1'b1, 1'b0, 1'b0, 9'h000);
    checkOutput("mr_first_req", imem_req, 1);
    checkOutput("mr_first_addr", imem_addr, 9'h000);
    applyStimulus(1'b1, 1'b0, 1'b0, 9'h000);
    applyStimulus(1'b1, 1'b0, 1'b0, 9'h000);
    applyStimulus(1'b1, 1'b0, 1'b0, 9'h000);
    checkOutput("mr_valid_c4", if_valid, 0);
    applyStimulus(1'b1, 1'b0, 1'b0, 9'h000);
    checkOutput("mr_valid_c5", if_valid, 1);
    checkOutput("mr_pc_c5", if_pc, 9'h000);
    checkOutput("mr_instr_c5", if_instr, instr_of(9'h000));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
